// File: rtl/step_pulse_gen.sv
// Step pulse generator: emits R evenly spaced one-cycle pulses per second for the
// selected walk/jog/run profile, or a fixed nine-second hybrid profile.
//
// state | meaning
// IDLE  | waiting for START, all counters clear
// RUN   | counting seconds and emitting pulses
// DONE  | hybrid profile finished, outputs quiet until START drops or MODE changes
module step_pulse_gen #(
  parameter int CLK_HZ = 100000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [1:0] MODE,
  output logic       PULSE,
  output logic       ACTIVE,
  output logic [3:0] SEC_INDEX
);

  localparam int CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] SEC_MAX = CW'(CLK_HZ - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] sec_cnt, sec_n, per_cnt, per_n;
  logic [7:0]    pcnt, pcnt_n, base;
  logic [3:0]    idx_n;
  logic [1:0]    mode_q;
  logic          pulse_n;

  function automatic logic [7:0] rate_of(input logic [1:0] md, input logic [3:0] sec);
    logic [7:0] r;
    r = 8'd0;
    case (md)
      2'b00: r = 8'd32;
      2'b01: r = 8'd64;
      2'b10: r = 8'd128;
      default: begin
        case (sec)
          4'd0: r = 8'd20;
          4'd1: r = 8'd33;
          4'd2: r = 8'd66;
          4'd3: r = 8'd27;
          4'd4: r = 8'd70;
          4'd5: r = 8'd30;
          4'd6: r = 8'd19;
          4'd7: r = 8'd30;
          4'd8: r = 8'd33;
          default: r = 8'd0;
        endcase
      end
    endcase
    return r;
  endfunction

  // Periods are elaboration-time constants; a zero-rate slot just never fires.
  function automatic logic [CW-1:0] period_of(input logic [1:0] md, input logic [3:0] sec);
    logic [CW-1:0] p;
    p = SEC_MAX;
    case (md)
      2'b00: p = CW'(CLK_HZ / 32);
      2'b01: p = CW'(CLK_HZ / 64);
      2'b10: p = CW'(CLK_HZ / 128);
      default: begin
        case (sec)
          4'd0: p = CW'(CLK_HZ / 20);
          4'd1: p = CW'(CLK_HZ / 33);
          4'd2: p = CW'(CLK_HZ / 66);
          4'd3: p = CW'(CLK_HZ / 27);
          4'd4: p = CW'(CLK_HZ / 70);
          4'd5: p = CW'(CLK_HZ / 30);
          4'd6: p = CW'(CLK_HZ / 19);
          4'd7: p = CW'(CLK_HZ / 30);
          4'd8: p = CW'(CLK_HZ / 33);
          default: p = SEC_MAX;
        endcase
      end
    endcase
    return p;
  endfunction

  always_comb begin
    state_n = state;
    sec_n   = '0;
    per_n   = '0;
    idx_n   = '0;
    base    = '0;
    if (!START) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: state_n = RUN;
        RUN, DONE: begin
          if (MODE != mode_q) begin
            state_n = RUN;
          end else if (state == DONE) begin
            idx_n = SEC_INDEX;
          end else if (sec_cnt == SEC_MAX) begin
            idx_n = (SEC_INDEX == 4'd9) ? 4'd9 : SEC_INDEX + 4'd1;
            if (MODE == 2'b11 && SEC_INDEX == 4'd8) state_n = DONE;
          end else begin
            sec_n = sec_cnt + CW'(1);
            idx_n = SEC_INDEX;
            base  = pcnt;
            per_n = (per_cnt == period_of(MODE, SEC_INDEX) - CW'(1)) ? '0 : per_cnt + CW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
    // Counters are already zero on restarts, so PERIOD-1 (>= 9) cannot match there.
    pulse_n = (state_n == RUN) && (per_n == period_of(MODE, idx_n) - CW'(1))
              && (base < rate_of(MODE, idx_n));
    pcnt_n  = base + {7'd0, pulse_n};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      sec_cnt   <= '0;
      per_cnt   <= '0;
      pcnt      <= '0;
      mode_q    <= '0;
      PULSE     <= 1'b0;
      ACTIVE    <= 1'b0;
      SEC_INDEX <= '0;
    end else begin
      state     <= state_n;
      sec_cnt   <= sec_n;
      per_cnt   <= per_n;
      pcnt      <= pcnt_n;
      mode_q    <= MODE;
      PULSE     <= pulse_n;
      ACTIVE    <= (state_n == RUN);
      SEC_INDEX <= idx_n;
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: arithmetic reference model checked every cycle, plus
// directed profile scenarios with hand-computed expectations and a random phase.
module tb_step_pulse_gen;
  localparam int CLK_HZ = 1280;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic [1:0] MODE = 2'b00;
  logic       PULSE, ACTIVE;
  logic [3:0] SEC_INDEX;

  int checks = 0;
  int errors = 0;

  step_pulse_gen #(.CLK_HZ(CLK_HZ)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .MODE(MODE),
    .PULSE(PULSE), .ACTIVE(ACTIVE), .SEC_INDEX(SEC_INDEX)
  );

  always #5 CLK = ~CLK;

  int hyb[9] = '{20, 33, 66, 27, 70, 30, 19, 30, 33};

  function automatic int rate_of(input logic [1:0] md, input int sec);
    case (md)
      2'b00: return 32;
      2'b01: return 64;
      2'b10: return 128;
      default: return (sec < 9) ? hyb[sec] : 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time since RUN was (re)entered, and the mode that run uses.
  bit         m_run = 0;
  int         m_t = 0;
  logic [1:0] m_mode = 2'b00;

  always @(posedge CLK) begin
    int sec, c, r, p, e_pulse, e_act, e_idx;
    if (RESET) m_run = 0;
    else if (!START) m_run = 0;
    else if (!m_run || MODE != m_mode) begin m_run = 1; m_t = 0; end
    else m_t++;
    m_mode = RESET ? 2'b00 : MODE;
    #1;
    e_pulse = 0; e_act = 0; e_idx = 0;
    if (m_run) begin
      sec = m_t / CLK_HZ;
      c   = m_t % CLK_HZ;
      if (m_mode == 2'b11 && sec >= 9) begin
        e_idx = 9;
      end else begin
        e_act = 1;
        e_idx = (sec > 9) ? 9 : sec;
        r = rate_of(m_mode, sec);
        if (r > 0) begin
          p = CLK_HZ / r;
          e_pulse = (((c + 1) % p) == 0 && ((c + 1) / p) <= r) ? 1 : 0;
        end
      end
    end
    check("model_pulse", int'(PULSE), e_pulse);
    check("model_active", int'(ACTIVE), e_act);
    check("model_sec_index", int'(SEC_INDEX), e_idx);
  end

  task automatic measure(input int ncyc, input int gap, output int cnt, output int first,
                         output int badgap);
    int last;
    cnt = 0; first = -1; badgap = 0; last = -1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge CLK);
      if (PULSE) begin
        if (first < 0) first = i;
        else if (i - last != gap) badgap++;
        last = i;
        cnt++;
      end
    end
  endtask

  task automatic cycles_to_pulse(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!PULSE && n < 200);
  endtask

  initial begin
    int cnt, first, bad, total, n;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rst_pulse", int'(PULSE), 0);
      check("rst_active", int'(ACTIVE), 0);
      check("rst_sec_index", int'(SEC_INDEX), 0);
    end

    // Walk: 32 pulses, first at cycle 39, 40 apart.
    RESET = 0; MODE = 2'b00; START = 1;
    measure(1280, 40, cnt, first, bad);
    check("walk_count", cnt, 32);
    check("walk_first", first, 39);
    check("walk_gaps", bad, 0);
    @(negedge CLK);
    check("walk_sec1", int'(SEC_INDEX), 1);

    // Run: change of mode restarts; two seconds give 256 pulses 10 apart.
    MODE = 2'b10;
    measure(2560, 10, cnt, first, bad);
    check("run_steps", cnt, 256);
    check("run_first", first, 9);
    check("run_gaps", bad, 0);

    // Hybrid profile then DONE.
    MODE = 2'b11;
    total = 0;
    for (int s = 0; s < 9; s++) begin
      measure(1280, 0, cnt, first, bad);
      check($sformatf("hyb_sec%0d", s), cnt, hyb[s]);
      total += cnt;
    end
    check("hyb_total", total, 328);
    measure(2560, 0, cnt, first, bad);
    check("done_pulses", cnt, 0);
    check("done_active", int'(ACTIVE), 0);
    check("done_sec_index", int'(SEC_INDEX), 9);
    START = 0;
    @(negedge CLK);
    check("idle_active", int'(ACTIVE), 0);
    check("idle_sec_index", int'(SEC_INDEX), 0);
    START = 1;
    @(negedge CLK);
    check("restart_active", int'(ACTIVE), 1);
    check("restart_sec_index", int'(SEC_INDEX), 0);

    // Mode change mid-second.
    START = 0; MODE = 2'b00;
    @(negedge CLK);
    START = 1;
    repeat (501) @(negedge CLK);
    MODE = 2'b01;
    @(negedge CLK);
    check("mchg_no_pulse", int'(PULSE), 0);
    n = 1;
    while (!PULSE && n < 200) begin @(negedge CLK); n++; end
    check("mchg_next_pulse", n, 20);
    check("mchg_sec_index", int'(SEC_INDEX), 0);

    // Reset mid-second with START held.
    START = 0; MODE = 2'b00;
    @(negedge CLK);
    START = 1;
    repeat (701) @(negedge CLK);
    RESET = 1;
    @(negedge CLK);
    check("midrst_pulse", int'(PULSE), 0);
    check("midrst_active", int'(ACTIVE), 0);
    check("midrst_sec_index", int'(SEC_INDEX), 0);
    RESET = 0;
    cycles_to_pulse(n);
    check("midrst_first_pulse", n, 40);

    // Random phase, checked only by the model.
    for (int i = 0; i < 8000; i++) begin
      int r;
      @(negedge CLK);
      r = $urandom_range(0, 999);
      RESET = (r < 3);
      if (r >= 3 && r < 6) START = ~START;
      else if (!START && r < 100) START = 1;
      if (r >= 6 && r < 12) MODE = 2'($urandom_range(0, 3));
    end

    @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
